// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams, transmitter handshake and grant status shared by uart_tx_arbiter.
// Requester i drives req_data[i] (bits [8i+7:8i] of the flat view).
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0][7:0] req_data;
  logic [NUM_REQ-1:0]      req_last;
  logic [NUM_REQ-1:0]      req_ready;
  logic [7:0]              tx_data;
  logic                    tx_start;
  logic                    tx_busy;
  logic                    grant_valid;
  logic [IDW-1:0]          grant_id;

  // master: requesters plus transmitter; slave: the arbiter
  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_data, tx_start, grant_valid, grant_id
  );
  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_data, tx_start, grant_valid, grant_id
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one UART byte transmitter between NUM_REQ requesters.
// A grant lasts until the last byte, MAX_BURST bytes, or STALL_CYCLES idle clocks.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 16,
  parameter int STALL_CYCLES = 65535
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int IW1 = IDW + 1;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SEND      = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  localparam logic [19:0]    STALL_MAX = 20'(STALL_CYCLES - 1);
  localparam logic [7:0]     BURST_MAX = 8'(MAX_BURST);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic           grant_valid_q, grant_valid_d;
  logic [7:0]     byte_cnt_q, byte_cnt_d;
  logic [19:0]    stall_cnt_q, stall_cnt_d;
  logic [1:0]     wb_cnt_q, wb_cnt_d;
  logic           last_q, last_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           tx_start_q, tx_start_d;

  logic [NUM_REQ-1:0] ready;
  logic [IW1-1:0]     rr_idx;
  logic [IDW-1:0]     pick_id;
  logic               pick_found;
  logic               hs;
  logic               rel;

  // First valid requester at or after rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    rr_idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_idx = {1'b0, rr_ptr_q} + IW1'(k);
      if (rr_idx >= IW1'(NUM_REQ)) rr_idx = rr_idx - IW1'(NUM_REQ);
      if (!pick_found && bus.req_valid[rr_idx[IDW-1:0]]) begin
        pick_found = 1'b1;
        pick_id    = rr_idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    ready = '0;
    if (state_q == SEND && grant_valid_q)
      ready[grant_id_q] = bus.req_valid[grant_id_q] & ~bus.tx_busy;
  end

  assign hs = ready[grant_id_q];

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    grant_valid_d = grant_valid_q;
    byte_cnt_d    = byte_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    wb_cnt_d      = wb_cnt_q;
    last_d        = last_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    rel           = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!bus.tx_busy && pick_found) begin
          grant_id_d    = pick_id;
          grant_valid_d = 1'b1;
          byte_cnt_d    = '0;
          stall_cnt_d   = '0;
          state_d       = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          tx_data_d   = bus.req_data[grant_id_q];
          tx_start_d  = 1'b1;
          byte_cnt_d  = byte_cnt_q + 8'd1;
          last_d      = bus.req_last[grant_id_q];
          stall_cnt_d = '0;
          wb_cnt_d    = '0;
          state_d     = WAIT_BUSY;
        end else if (!bus.req_valid[grant_id_q]) begin
          if (stall_cnt_q >= STALL_MAX) rel = 1'b1;
          else stall_cnt_d = stall_cnt_q + 20'd1;
        end
      end
      // Bounded wait so a transmitter that never reports busy cannot wedge the grant.
      WAIT_BUSY: begin
        if (bus.tx_busy || wb_cnt_q == 2'd3) state_d = WAIT_DONE;
        else wb_cnt_d = wb_cnt_q + 2'd1;
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (last_q || byte_cnt_q == BURST_MAX) rel = 1'b1;
          else state_d = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rel) begin
      grant_valid_d = 1'b0;
      rr_ptr_d      = (grant_id_q == LAST_ID) ? '0 : grant_id_q + IDW'(1);
      state_d       = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_id_q    <= '0;
      rr_ptr_q      <= '0;
      grant_valid_q <= 1'b0;
      byte_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      wb_cnt_q      <= '0;
      last_q        <= 1'b0;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_valid_q <= grant_valid_d;
      byte_cnt_q    <= byte_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      wb_cnt_q      <= wb_cnt_d;
      last_q        <= last_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
    end
  end

  assign bus.req_ready   = ready;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_id    = grant_id_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued requesters, a frame-length transmitter model, and a
// packet-level round-robin model predicting the byte/requester order seen on tx_start.
module tb_uart_tx_arbiter;
  localparam int N     = 4;
  localparam int MB    = 4;
  localparam int SC    = 100;
  localparam int IDW   = 2;
  localparam int DEPTH = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();
  uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .STALL_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  logic [8:0] mem [N][DEPTH];
  int hd [N];
  int tl [N];
  logic [N-1:0] pend = '0;
  int frame_len = 2340;
  int busy_cnt  = 0;
  int cyc       = 0;
  bit nobusy    = 1'b0;
  logic [IDW-1:0] obs_id [DEPTH];
  logic [7:0]     obs_b  [DEPTH];
  int             obs_t  [DEPTH];
  int             obs_n  = 0;
  logic [IDW-1:0] exp_id [DEPTH];
  logic [7:0]     exp_b  [DEPTH];
  int             exp_n  = 0;
  int             mptr   = 0;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Requesters present their queue heads; the transmitter is busy frame_len cycles per start.
  always @(negedge clk) begin
    logic [N-1:0] gmask;
    cyc++;
    for (int i = 0; i < N; i++) if (pend[i]) hd[i]++;
    if (bus.tx_start === 1'b1) begin
      if (obs_n < DEPTH) begin
        obs_id[obs_n] = bus.grant_id;
        obs_b[obs_n]  = bus.tx_data;
        obs_t[obs_n]  = cyc;
        obs_n++;
      end
      if (!nobusy) busy_cnt = frame_len;
    end
    bus.tx_busy = (busy_cnt > 0);
    if (busy_cnt > 0) busy_cnt--;
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = (hd[i] < tl[i]);
      {bus.req_last[i], bus.req_data[i]} = bus.req_valid[i] ? mem[i][hd[i]] : 9'h0;
    end
    #1;
    gmask = bus.grant_valid ? (N'(1) << bus.grant_id) : '0;
    chk("ready_onehot0", 32'($onehot0(bus.req_ready)), 32'd1);
    chk("ready_nongranted", 32'(bus.req_ready & ~gmask), 32'd0);
    chk("ready_without_valid", 32'(bus.req_ready & ~bus.req_valid), 32'd0);
    pend = bus.req_valid & bus.req_ready;
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic push(input int r, input logic [7:0] b, input logic l);
    mem[r][tl[r]] = {l, b};
    tl[r]++;
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (hd[i] != tl[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit cond(input int what, input int arg);
    case (what)
      0:       return obs_n >= arg;
      1:       return bus.tx_busy === 1'b1;
      2:       return bus.tx_busy === 1'b0;
      3:       return bus.grant_valid === 1'b0;
      default: return bus.grant_valid === 1'b1;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int what, input int arg, input int lim, output int n);
    bit hit;
    n = 0;
    hit = cond(what, arg);
    while (!hit && n < lim) begin
      tick();
      n++;
      hit = cond(what, arg);
    end
    chk({tag, "_timeout"}, 32'(hit), 32'd1);
  endtask

  // Packet-level model: each grant goes to the next non-empty queue from the pointer and
  // takes bytes until a last flag, MB bytes, or the queue runs dry (stall release).
  task automatic build_expected();
    int h [N];
    int p, id, cnt;
    logic [8:0] e;
    bit any;
    for (int i = 0; i < N; i++) h[i] = hd[i];
    p = mptr;
    exp_n = 0;
    id = 0;
    do begin
      any = 1'b0;
      for (int k = 0; k < N && !any; k++) begin
        id = (p + k) % N;
        if (h[id] < tl[id]) any = 1'b1;
      end
      if (any) begin
        cnt = 0;
        do begin
          e = mem[id][h[id]];
          h[id]++;
          exp_id[exp_n] = IDW'(id);
          exp_b[exp_n]  = e[7:0];
          exp_n++;
          cnt++;
        end while (!e[8] && cnt < MB && h[id] < tl[id]);
        p = (id + 1) % N;
      end
    end while (any);
    mptr = p;
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_count"}, 32'(obs_n), 32'(exp_n));
    for (int i = 0; i < exp_n && i < obs_n; i++) begin
      chk({tag, "_id"}, 32'(obs_id[i]), 32'(exp_id[i]));
      chk({tag, "_byte"}, 32'(obs_b[i]), 32'(exp_b[i]));
    end
  endtask

  task automatic drain(input string tag, input int lim);
    bit done;
    done = 1'b0;
    for (int n = 0; n < lim && !done; n++) begin
      tick();
      done = all_empty() && bus.grant_valid === 1'b0 && bus.tx_busy === 1'b0;
    end
    chk({tag, "_drain_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    mptr = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
    chk({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_grant_valid"}, 32'(bus.grant_valid), 32'd0);
    chk({tag, "_grant_id"}, 32'(bus.grant_id), 32'd0);
  endtask

  initial begin
    int n, npk, len;
    for (int i = 0; i < N; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    do_reset();
    check_reset_vals("rst0");

    // Single requester, 3-byte packet, full-length frames.
    frame_len = 2340;
    obs_n = 0;
    push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b0); push(0, 8'h43, 1'b1);
    build_expected();
    wait_for("a_three", 0, 3, 10000, n);
    wait_for("a_busy", 1, 0, 10, n);
    wait_for("a_idle", 2, 0, 3000, n);
    chk("a_grant_held", 32'(bus.grant_valid), 32'd1);
    tick();
    chk("a_grant_released", 32'(bus.grant_valid), 32'd0);
    drain("a", 100);
    check_log("a");

    // Two simultaneous 2-byte packets after reset: pointer 0 serves requester 0 first.
    do_reset();
    frame_len = 25;
    obs_n = 0;
    push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b1);
    push(2, 8'hC0, 1'b0); push(2, 8'hC1, 1'b1);
    build_expected();
    drain("b", 2000);
    check_log("b");

    // Burst limit splits requester 1's 6-byte run around requester 3's packet.
    do_reset();
    obs_n = 0;
    for (int i = 0; i < 6; i++) push(1, 8'(8'h60 + i), 1'b0);
    push(3, 8'hD0, 1'b0); push(3, 8'hD1, 1'b1);
    build_expected();
    drain("c", 4000);
    check_log("c");

    // Stall release exactly STALL_CYCLES clocks into SEND with valid low.
    do_reset();
    frame_len = 20;
    obs_n = 0;
    push(0, 8'h5A, 1'b0);
    push(1, 8'h3C, 1'b1);
    build_expected();
    wait_for("d_start", 0, 1, 50, n);
    wait_for("d_busy", 1, 0, 10, n);
    wait_for("d_idle", 2, 0, 100, n);
    wait_for("d_release", 3, 0, 300, n);
    chk("d_stall_cycles", 32'(n), 32'(SC + 1));
    wait_for("d_regrant", 4, 0, 20, n);
    chk("d_next_id", 32'(bus.grant_id), 32'd1);
    drain("d", 500);
    check_log("d");

    // Reset in the middle of a frame with requester 2 still asking.
    frame_len = 60;
    obs_n = 0;
    push(2, 8'hA5, 1'b1);
    wait_for("e_start", 0, 1, 50, n);
    wait_for("e_busy", 1, 0, 10, n);
    repeat (5) tick();
    push(2, 8'h6B, 1'b1);
    rst = 1'b1;
    tick();
    check_reset_vals("e_rst");
    rst = 1'b0;
    push(0, 8'h11, 1'b1);
    mptr = 0;
    obs_n = 0;
    build_expected();
    n = 0;
    while (bus.tx_busy === 1'b1 && n < 200) begin
      chk("e_no_grant_busy", 32'(bus.grant_valid), 32'd0);
      tick();
      n++;
    end
    drain("e", 500);
    check_log("e");

    // Transmitter that never reports busy: 4 WAIT_BUSY + WAIT_DONE + SEND between starts.
    nobusy = 1'b1;
    obs_n = 0;
    push(3, 8'h10, 1'b0); push(3, 8'h20, 1'b0); push(3, 8'h30, 1'b1);
    build_expected();
    drain("f", 200);
    check_log("f");
    if (obs_n >= 3) begin
      chk("f_gap0", 32'(obs_t[1] - obs_t[0]), 32'd6);
      chk("f_gap1", 32'(obs_t[2] - obs_t[1]), 32'd6);
    end
    nobusy = 1'b0;

    // Randomized rounds without reset; the model carries the pointer across rounds.
    for (int r = 0; r < 6; r++) begin
      frame_len = $urandom_range(8, 40);
      nobusy = ($urandom_range(0, 3) == 0);
      obs_n = 0;
      for (int i = 0; i < N; i++) begin
        npk = $urandom_range(0, 3);
        for (int p = 0; p < npk; p++) begin
          len = $urandom_range(1, 6);
          for (int b = 0; b < len; b++) push(i, 8'($urandom), b == len - 1);
        end
      end
      build_expected();
      drain("rnd", 10000);
      check_log("rnd");
    end
    nobusy = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
